// File: rtl/flash_rs_dump_pkg.sv
// Shared definitions for the flash-to-RS232 dump engine and its serial transmitter.
// The state encodings live here so the reader-side manager FSM decodes the same values.
package flash_rs_dump_pkg;

    localparam logic [2:0] EncIdle   = 3'd0;
    localparam logic [2:0] EncReqFl  = 3'd1;
    localparam logic [2:0] EncWaitFl = 3'd2;
    localparam logic [2:0] EncSendRs = 3'd3;
    localparam logic [2:0] EncWaitRs = 3'd4;
    localparam logic [2:0] EncStop   = 3'd5;

    typedef enum logic [2:0] {
        StIdle   = EncIdle,
        StReqFl  = EncReqFl,
        StWaitFl = EncWaitFl,
        StSendRs = EncSendRs,
        StWaitRs = EncWaitRs,
        StStop   = EncStop
    } state_e;

    localparam int unsigned DefaultBaudDiv = 434;
    localparam int unsigned FrameBits      = 10;
    localparam int unsigned FlAddrW        = 22;

    // Counter width helper: never returns a zero-width vector.
    function automatic int unsigned clog2_min1(input int unsigned v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/flash_rs_dump_if.sv
// Flash read bus: level request with address, one-cycle acknowledge with data.
interface flash_rs_dump_if;
    import flash_rs_dump_pkg::*;

    logic               FL_RD_REQ;
    logic [FlAddrW-1:0] FL_ADDR;
    logic               FL_RD_ACK;
    logic [7:0]         FL_DATA;

    modport master (output FL_RD_REQ, FL_ADDR, input FL_RD_ACK, FL_DATA);
    modport slave  (input FL_RD_REQ, FL_ADDR, output FL_RD_ACK, FL_DATA);

endinterface

// File: rtl/flash_rs_dump_uart_tx.sv
// 8N1 serial transmitter; every bit lasts BAUD_DIV clocks, TXD is registered.
module uart_tx
    import flash_rs_dump_pkg::*;
#(
    parameter int unsigned BAUD_DIV = DefaultBaudDiv
) (
    input  logic       CLK_50MHZ,
    input  logic       RST,
    input  logic       TX_START,
    input  logic [7:0] TX_DATA,
    output logic       TX_BUSY,
    output logic       TXD
);

    localparam int unsigned BaudW = clog2_min1(BAUD_DIV);
    localparam int unsigned BitW  = clog2_min1(FrameBits);

    logic [BaudW-1:0] baud_q, baud_d;
    logic [BitW-1:0]  bit_q, bit_d;
    logic [8:0]       shift_q, shift_d;
    logic             busy_q, busy_d;
    logic             txd_q, txd_d;

    always_ff @(posedge CLK_50MHZ) begin
        if (RST) begin
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '1;
            busy_q  <= 1'b0;
            txd_q   <= 1'b1;
        end else begin
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            busy_q  <= busy_d;
            txd_q   <= txd_d;
        end
    end

    // bit_q is the frame bit currently on the line; shift_q holds data then the stop bit.
    always_comb begin
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        busy_d  = busy_q;
        txd_d   = txd_q;
        if (!busy_q) begin
            if (TX_START) begin
                busy_d  = 1'b1;
                txd_d   = 1'b0;
                shift_d = {1'b1, TX_DATA};
                baud_d  = '0;
                bit_d   = '0;
            end
        end else if (baud_q == BaudW'(BAUD_DIV - 1)) begin
            baud_d = '0;
            if (bit_q == BitW'(FrameBits - 1)) begin
                busy_d = 1'b0;
                txd_d  = 1'b1;
            end else begin
                bit_d   = bit_q + BitW'(1);
                txd_d   = shift_q[0];
                shift_d = {1'b1, shift_q[8:1]};
            end
        end else begin
            baud_d = baud_q + BaudW'(1);
        end
    end

    assign TX_BUSY = busy_q;
    assign TXD     = txd_q;

endmodule

// File: rtl/flash_rs_dump.sv
// Reads LEN bytes from flash starting at BASE_ADDR and sends each one out over RS232.
// ERR flags a flash read that was never acknowledged and stays set until the next dump.
module flash_rs_dump
    import flash_rs_dump_pkg::*;
#(
    parameter int unsigned        BAUD_DIV   = DefaultBaudDiv,
    parameter logic [FlAddrW-1:0] BASE_ADDR  = 22'h000000,
    parameter int unsigned        FL_TIMEOUT = 1023
) (
    input  logic                   CLK_50MHZ,
    input  logic                   RST,
    input  logic                   START,
    input  logic [7:0]             LEN,
    flash_rs_dump_if.master        fl,
    output logic                   RS_TXD,
    output logic                   BUSY,
    output logic                   DONE,
    output logic                   ERR
);

    localparam int unsigned TmoW = clog2_min1(FL_TIMEOUT);

    state_e             state_q, state_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [FlAddrW-1:0] addr_q, addr_d;
    logic [7:0]         byte_q, byte_d;
    logic [TmoW-1:0]    tmo_q, tmo_d;
    logic               err_q, err_d;
    logic               tx_start;
    logic               tx_busy;

    always_ff @(posedge CLK_50MHZ) begin
        if (RST) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            addr_q  <= BASE_ADDR;
            byte_q  <= '0;
            tmo_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            byte_q  <= byte_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        byte_d   = byte_q;
        tmo_d    = tmo_q;
        err_d    = err_q;
        tx_start = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (START) begin
                    err_d = 1'b0;
                    if (LEN != 8'd0) begin
                        cnt_d   = LEN;
                        addr_d  = BASE_ADDR;
                        state_d = StReqFl;
                    end else begin
                        state_d = StStop;
                    end
                end
            end
            StReqFl: begin
                tmo_d   = '0;
                state_d = StWaitFl;
            end
            StWaitFl: begin
                if (fl.FL_RD_ACK) begin
                    byte_d  = fl.FL_DATA;
                    state_d = StSendRs;
                end else if (tmo_q == TmoW'(FL_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = StStop;
                end else begin
                    tmo_d = tmo_q + TmoW'(1);
                end
            end
            StSendRs: begin
                tx_start = 1'b1;
                state_d  = StWaitRs;
            end
            StWaitRs: begin
                // tx_busy is already high in the first cycle here, set by the same edge.
                if (!tx_busy) begin
                    addr_d  = addr_q + FlAddrW'(1);
                    cnt_d   = cnt_q - 8'd1;
                    state_d = (cnt_q == 8'd1) ? StStop : StReqFl;
                end
            end
            StStop: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    uart_tx #(
        .BAUD_DIV (BAUD_DIV)
    ) u_uart_tx (
        .CLK_50MHZ (CLK_50MHZ),
        .RST       (RST),
        .TX_START  (tx_start),
        .TX_DATA   (byte_q),
        .TX_BUSY   (tx_busy),
        .TXD       (RS_TXD)
    );

    assign fl.FL_RD_REQ = (state_q == StReqFl) || (state_q == StWaitFl);
    assign fl.FL_ADDR   = addr_q;
    assign BUSY         = (state_q != StIdle);
    assign DONE         = (state_q == StStop);
    assign ERR          = err_q;

endmodule

// File: doc/flash_rs_dump.md
FLASH_RS_DUMP -- requirements
Module: flash_rs_dump

Interface
REQ-001 The clock SHALL be CLK_50MHZ; the reset SHALL be RST, synchronous, active-high.
REQ-002 Parameters SHALL be, one per line:
- BAUD_DIV, 434, CLK_50MHZ cycles per UART bit (115200 baud).
- BASE_ADDR, 22'h000000, first flash byte address read.
- FL_TIMEOUT, 1023, maximum cycles to wait for FL_RD_ACK.
REQ-003 Ports SHALL be, one per line:
- CLK_50MHZ  in  1  clock.
- RST  in  1  synchronous active-high reset.
- START  in  1  one-cycle request to begin a dump.
- LEN  in  8  byte count; sampled when START is accepted.
- FL_RD_REQ  out  1  flash read request, level.
- FL_ADDR  out  22  flash byte address.
- FL_RD_ACK  in  1  flash data valid, one-cycle pulse.
- FL_DATA  in  8  flash read data; valid when FL_RD_ACK=1.
- RS_TXD  out  1  RS232 serial output, idle high.
- BUSY  out  1  dump in progress.
- DONE  out  1  one-cycle pulse at dump end.
- ERR  out  1  flash timeout flag, sticky.

Function
REQ-004 States SHALL be IDLE, REQ_FL, WAIT_FL, SEND_RS, WAIT_RS, STOP.
REQ-005 IDLE: START=1 with LEN>0 SHALL latch LEN into the remaining-byte counter, set FL_ADDR=BASE_ADDR, clear ERR, and go to REQ_FL.
REQ-006 IDLE: START=1 with LEN=0 SHALL clear ERR and go to STOP; no flash request is issued and RS_TXD stays high.
REQ-007 REQ_FL SHALL assert FL_RD_REQ for exactly one cycle, then go to WAIT_FL.
REQ-008 WAIT_FL SHALL hold FL_RD_REQ=1 and FL_ADDR stable until FL_RD_ACK=1.
REQ-009 In the FL_RD_ACK cycle, FL_DATA SHALL be captured into the byte register and the state SHALL go to SEND_RS.
REQ-010 If WAIT_FL lasts FL_TIMEOUT cycles without FL_RD_ACK, ERR SHALL be set and the state SHALL go to STOP.
REQ-011 SEND_RS SHALL pulse the transmitter start for one cycle, then go to WAIT_RS.
REQ-012 WAIT_RS SHALL wait for the transmitter to go idle. On completion:
- increment FL_ADDR by 1, with 22-bit wrap from 3FFFFF to 000000;
- decrement the counter;
- go to REQ_FL if the counter is nonzero, else to STOP.
REQ-013 STOP SHALL assert DONE for exactly one cycle, then go to IDLE.
REQ-014 BUSY SHALL be 1 in every state except IDLE.
REQ-015 START SHALL be ignored while BUSY=1.
REQ-016 The transmitter SHALL use 8N1 framing: start bit 0, data LSB first, stop bit 1.
REQ-017 Every transmitted bit SHALL last exactly BAUD_DIV cycles, so one frame lasts 10*BAUD_DIV cycles.
REQ-018 The first start-bit edge on RS_TXD SHALL occur 1 cycle after the transmitter start pulse.
REQ-019 A FL_RD_ACK outside WAIT_FL SHALL be ignored.
REQ-020 ERR SHALL persist through DONE and IDLE until the next accepted START or RST.

Reset
REQ-021 Under RST=1 the block SHALL hold the following values and abort any frame in progress:
- state=IDLE;
- RS_TXD=1;
- FL_RD_REQ=0, BUSY=0, DONE=0, ERR=0;
- FL_ADDR=BASE_ADDR;
- counter=0.
REQ-022 An assertion of RST mid-frame or mid-read SHALL produce no DONE pulse.

Structure
REQ-023 The state encodings (3-bit localparams) and the default baud divisor SHALL live in a shared package/include file. The reader-side manager FSM SHALL use the same file.
REQ-024 The serial transmitter SHALL be a sub-module uart_tx with the following ports:
- CLK_50MHZ, RST;
- TX_START, TX_DATA[7:0];
- TX_BUSY, TXD.
REQ-025 uart_tx SHALL take BAUD_DIV as a parameter; the baud counter and the bit counter SHALL each be sized with ceil-log2.

Verification
REQ-026 All scenarios below SHALL run with BAUD_DIV=4 unless stated.
REQ-027 Basic dump: LEN=3, BASE_ADDR=0, flash returns 8'hA5, 8'h3C, 8'hFF with a 2-cycle ACK latency -> the following responses:
- RS_TXD shows 3 frames of 40 cycles each, LSB first;
- FL_ADDR steps 0, 1, 2;
- one DONE pulse;
- BUSY falls on the DONE cycle + 1.
REQ-028 Zero length: LEN=0 START -> FL_RD_REQ never asserts and RS_TXD stays 1; DONE pulses on the 2nd cycle after START.
REQ-029 Timeout: FL_TIMEOUT=16 and FL_RD_ACK is never given -> ERR=1 after 16 WAIT_FL cycles; DONE pulses; no frame is sent.
REQ-030 Reset mid-frame: RST is applied during bit 4 of the first byte -> RS_TXD=1 on the next cycle, state=IDLE, no DONE pulse.
REQ-031 Wrap and ignored START: BASE_ADDR=22'h3FFFFE with LEN=3 -> FL_ADDR takes 3FFFFE, 3FFFFF, 000000. A second START issued mid-dump is ignored.
